// File: rtl/prog_freq_divider.sv
// prog_freq_divider: runtime-programmable integer clock divider.
// Single clk domain. Produces a duty-balanced divided output, a one-cycle
// period tick and optional power-of-two taps (enable with FREQDIV_TAPS_EN).
// Divisor changes are staged in a pending register and applied on a period
// boundary, or immediately while the divider is disabled.
module prog_freq_divider #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned TAPS        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             load_busy,
  output logic             div_out,
  output logic             div_tick,
  output logic [TAPS-1:0]  tap_out
);

  localparam int unsigned HALF_W = CNT_W + 1;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_act;
  logic [CNT_W-1:0]  n_pend;
  logic [CNT_W-1:0]  term_cnt;
  logic [HALF_W-1:0] high_len;
  logic [CNT_W-1:0]  load_val;
  logic              wrap;
  logic              apply;

  // Terminal count, high-phase length ceil(N/2), wrap/apply decisions.
  always_comb begin
    term_cnt = n_act - CNT_W'(1);
    high_len = (HALF_W'(n_act) + HALF_W'(1)) >> 1;
    wrap     = en && (cnt == term_cnt);
    apply    = load_busy && (wrap || !en);
    load_val = (div_val == '0) ? CNT_W'(1) : div_val;
  end

  // Period counter, registered outputs and divisor staging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      n_act     <= CNT_W'(DEFAULT_DIV);
      n_pend    <= CNT_W'(DEFAULT_DIV);
      load_busy <= 1'b0;
      div_out   <= 1'b0;
      div_tick  <= 1'b0;
    end else begin
      if (en) begin
        cnt      <= wrap ? '0 : cnt + CNT_W'(1);
        div_out  <= (HALF_W'(cnt) < high_len);
        div_tick <= wrap;
      end else begin
        div_tick <= 1'b0;
      end
      // A staged divisor lands on a period boundary, or at once when frozen
      // (restarting the phase so the new period begins cleanly).
      if (apply) begin
        n_act     <= n_pend;
        load_busy <= 1'b0;
        if (!en) begin
          cnt <= '0;
        end
      end
      // A fresh load always wins the busy flag and replaces the pending value.
      if (div_load) begin
        n_pend    <= load_val;
        load_busy <= 1'b1;
      end
    end
  end

`ifdef FREQDIV_TAPS_EN
  logic [TAPS-1:0] tap_cnt;

  // Binary period counter; bit k toggles every 2^k periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt <= '0;
    end else if (wrap) begin
      tap_cnt <= tap_cnt + TAPS'(1);
    end
  end

  assign tap_out = tap_cnt;
`else
  assign tap_out = '0;
`endif

endmodule

// File: tb/tb_prog_freq_divider.sv
// Scoreboard bench for prog_freq_divider: stimulus pushes the reference
// model's expected outputs, a monitor pops and compares after each edge.
module tb_prog_freq_divider;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEF   = 2;
  localparam int unsigned TAPS  = 3;

  logic             clk;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             load_busy;
  logic             div_out;
  logic             div_tick;
  logic [TAPS-1:0]  tap_out;

  prog_freq_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .load_busy(load_busy), .div_out(div_out), .div_tick(div_tick),
    .tap_out(tap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int tick;
    int busy;
    int taps;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference state: phase within the current period, active/pending divisor,
  // completed-period count and registered outputs.
  int m_phase, m_n, m_pend, m_busy, m_periods, m_dout, m_tick;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_taps();
`ifdef FREQDIV_TAPS_EN
    return m_periods % (1 << TAPS);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_n = DEF; m_pend = DEF; m_busy = 0;
    m_periods = 0; m_dout = 0; m_tick = 0;
  endtask

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic model_step(input int e, input int ld, input int val);
    int last;
    int nphase, nn;
    last   = (e != 0) && (m_phase == m_n - 1);
    nphase = m_phase;
    nn     = m_n;
    if (e != 0) begin
      m_dout = (m_phase < (m_n + 1) / 2) ? 1 : 0;
      m_tick = last;
      nphase = last ? 0 : m_phase + 1;
      if (last) m_periods++;
    end else begin
      m_tick = 0;
    end
    if (m_busy != 0 && (last != 0 || e == 0)) begin
      nn = m_pend;
      m_busy = 0;
      if (e == 0) nphase = 0;
    end
    if (ld != 0) begin
      m_pend = (val == 0) ? 1 : val;
      m_busy = 1;
    end
    m_phase = nphase;
    m_n     = nn;
  endtask

  task automatic push_exp();
    exp_t x;
    x.dout = m_dout; x.tick = m_tick; x.busy = m_busy; x.taps = exp_taps();
    exp_q.push_back(x);
  endtask

  // One clock cycle of stimulus, driven on the falling edge.
  task automatic cyc(input int e, input int ld, input int val);
    @(negedge clk);
    rst      = 1'b0;
    en       = (e != 0);
    div_load = (ld != 0);
    div_val  = CNT_W'(val);
    model_step(e, ld, val);
    push_exp();
  endtask

  // Mid-period asynchronous reset, checked before any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; div_load = 1'b0; div_val = '0;
    #1;
    chk("async_rst_div_out", int'(div_out), 0);
    chk("async_rst_div_tick", int'(div_tick), 0);
    chk("async_rst_load_busy", int'(load_busy), 0);
    chk("async_rst_tap_out", int'(tap_out), 0);
    model_reset();
    push_exp();
  endtask

  // Monitor: compare one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("div_out", int'(div_out), e.dout);
        chk("div_tick", int'(div_tick), e.tick);
        chk("load_busy", int'(load_busy), e.busy);
        chk("tap_out", int'(tap_out), e.taps);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
    model_reset();
    #3;
    chk("reset_div_out", int'(div_out), 0);
    chk("reset_div_tick", int'(div_tick), 0);
    chk("reset_load_busy", int'(load_busy), 0);
    chk("reset_tap_out", int'(tap_out), 0);

    // Default divide-by-2 straight out of reset.
    repeat (8) cyc(1, 0, 0);

    // Load 5 while frozen, then run.
    cyc(0, 1, 5);
    cyc(0, 0, 0);
    repeat (15) cyc(1, 0, 0);

    // N=6 running, then load 3 when the phase is 1.
    cyc(1, 1, 6);
    repeat (14) cyc(1, 0, 0);
    guard = 0;
    while (!(m_n == 6 && m_busy == 0 && m_phase == 1) && guard < 40) begin
      cyc(1, 0, 0);
      guard++;
    end
    if (guard >= 40) chk("seek_phase1_timeout", guard, 0);
    cyc(1, 1, 3);
    repeat (12) cyc(1, 0, 0);

    // Loads of 0 then 1, followed by a 3-cycle freeze.
    cyc(1, 1, 0);
    repeat (8) cyc(1, 0, 0);
    cyc(1, 1, 1);
    repeat (8) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    repeat (5) cyc(1, 0, 0);

    // N=4 long run for the taps.
    cyc(1, 1, 4);
    repeat (80) cyc(1, 0, 0);

    // Back-to-back loads while busy; only the last one should stick.
    cyc(1, 1, 9);
    cyc(1, 1, 2);
    cyc(1, 1, 7);
    repeat (20) cyc(1, 0, 0);

    // Reset mid-period with a load pending.
    cyc(1, 1, 3);
    pulse_reset();
    repeat (10) cyc(1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int e, ld, v;
      e  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      ld = ($urandom_range(0, 24) == 0) ? 1 : 0;
      v  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 10));
      if ($urandom_range(0, 999) == 0) pulse_reset();
      else cyc(e, ld, v);
    end

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_freq_divider.md
# prog_freq_divider

Runtime-programmable integer clock divider, the parametrised successor to the fixed div2/div4/div8 ripple divider. It produces a divided clock-like output of any ratio N, a one-cycle period tick, and a bank of synchronous power-of-two taps (÷2N, ÷4N, …). All logic is in the single `clk` domain with no derived clocks, so downstream logic consumes `div_tick` as an enable. It sits in the clocking/timebase area and feeds timers, baud generators and LED/strobe logic.

## Interface
- `CNT_W`, default 8: width of the divisor and period counter; N range 1..2^CNT_W-1.
- `DEFAULT_DIV`, default 2: active divisor after reset; must satisfy 1 ≤ DEFAULT_DIV ≤ 2^CNT_W-1.
- `TAPS`, default 3: number of power-of-two tap outputs; ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; low freezes the divider.
- `div_val`  in  CNT_W  new divisor N; the value 0 is treated as 1.
- `div_load`  in  1  single-cycle strobe; captures `div_val` into the pending register.
- `load_busy`  out  1  high while a captured divisor is waiting to be applied.
- `div_out`  out  1  divided output; period N, high for ceil(N/2) cycles.
- `div_tick`  out  1  one-cycle pulse, once per N enabled cycles.
- `tap_out`  out  TAPS  bit k toggles every 2^k periods, giving ÷(N·2^(k+1)).

## Operation
- State: `cnt` (CNT_W), `n_act` (active divisor), `n_pend`, `load_busy`, registered `div_out`/`div_tick`, `tap_cnt` (TAPS).
- Wrap condition: `wrap` = `en` && `cnt` == `n_act`-1. Since N=1 gives a terminal count of 0, `wrap` is true on every enabled cycle.
- Enabled edge:
  - `cnt` <= `wrap` ? 0 : `cnt`+1.
  - `div_out` <= (`cnt` < ceil(`n_act`/2)), using the pre-edge `cnt`.
  - `div_tick` <= `wrap`.
  - `tap_cnt` increments (mod 2^TAPS) when `wrap`.
- Disabled edge:
  - `cnt`, `div_out` and `tap_cnt` hold.
  - `div_tick` <= 0.
- Load:
  - `div_load` sets `n_pend` <= max(`div_val`,1) and `load_busy` <= 1.
  - A second load while busy overwrites `n_pend`. Only the last value is applied.
- Apply, when `load_busy` is already high at the edge:
  - If `wrap`: `n_act` <= `n_pend`. The new period starts at `cnt`=0.
  - If `en` is low: `n_act` <= `n_pend` and `cnt` <= 0, so the phase restarts. `div_out` holds.
  - In both cases `load_busy` <= 0, unless `div_load` is also high that cycle. Then the old pending value is applied, the new value becomes pending, and `load_busy` stays 1.
- A `div_load` that arrives while not busy is never applied on the same edge, even on a wrap edge.
- N=1: `div_out` is constantly 1 and `div_tick` is high on every enabled cycle.

## Timing
- Reset values:
  - `cnt`=0, `n_act`=DEFAULT_DIV, `n_pend`=DEFAULT_DIV.
  - `load_busy`=0, `div_out`=0, `div_tick`=0, `tap_cnt`=0, so `tap_out`=0.
- Reset asserted mid-operation clears all state immediately, including any pending load.
- `div_out` and `div_tick` lag `cnt` by one cycle.
- `div_tick` is high in the cycle before `div_out` rises.
- `load_busy` rises one cycle after the `div_load` edge.
- New N takes effect at the first wrap at least one edge after capture. Worst-case latency is old N + 1 cycles.
- `tap_out[k]` changes on the same edge that sets `div_tick`.

## Configuration
- `FREQDIV_TAPS_EN` defined: `tap_cnt` is implemented and `tap_out` behaves as above.
- `FREQDIV_TAPS_EN` undefined: no tap counter is implemented and `tap_out` is tied to 0. All other behaviour is identical.

## Test plan
- Reset release, `en`=1, DEFAULT_DIV=2 -> `div_out` toggles every cycle starting 1 at edge 1; `div_tick` high on edges 2, 4, 6, …
- `div_val`=5 loaded while `en`=0 -> `load_busy` high 1 cycle, then `cnt`=0. With `en`=1, `div_out` pattern is 1,1,1,0,0 repeating and `div_tick` fires every 5 cycles.
- N=6 running, load 3 at `cnt`=1 -> remaining 4 cycles at N=6, then period 3 (`div_out` 1,1,0). `load_busy` drops on the wrap edge.
- Loads of 0 and then 1 -> `div_out` stays 1 and `div_tick` is high every enabled cycle. Dropping `en` for 3 cycles -> `div_tick` is 0 for 3 cycles and `cnt` is held.
- N=4, TAPS=3, macro defined -> `tap_out[0]` period 8, `tap_out[1]` period 16, `tap_out[2]` period 32. Macro undefined -> `tap_out`=0 always.
- `rst` pulsed mid-period with a load pending -> all outputs return to reset values asynchronously, `n_act` returns to DEFAULT_DIV, and the pending value is discarded.
